// File: rtl/exec_writeback.sv
// -----------------------------------------------------------------------------
// exec_writeback
//   Execute-to-writeback boundary stage. It captures ALU results and flags,
//   keeps the processor status register (CLFZN), and buffers register
//   writebacks in a 2-entry FIFO so that a stalled register file port does
//   not stall the ALU straight away. It also evaluates branch condition codes
//   against the current PSR.
// -----------------------------------------------------------------------------
module exec_writeback #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    // ALU result side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [4:0]       in_flags,
    input  logic [4:0]       in_flag_mask,
    input  logic             in_wr_reg,
    input  logic [3:0]       in_dest,

    // Direct PSR write and status
    input  logic             psr_load,
    input  logic [4:0]       psr_data,
    output logic [4:0]       psr,
    output logic             carry,

    // Branch condition evaluation
    input  logic [3:0]       cond,
    output logic             cond_true,

    // Register file writeback side
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       wb_dest
);

    // PSR bit positions
    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    // One buffered writeback
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [3:0]       dest;
    } wb_entry_t;

    // Condition code encodings
    typedef enum logic [3:0] {
        CC_EQ  = 4'b0000,   // Z
        CC_NE  = 4'b0001,   // ~Z
        CC_CS  = 4'b0010,   // C
        CC_CC  = 4'b0011,   // ~C
        CC_LT  = 4'b0100,   // L
        CC_GE  = 4'b0101,   // ~L
        CC_MI  = 4'b0110,   // N
        CC_PL  = 4'b0111,   // ~N
        CC_FS  = 4'b1000,   // F
        CC_FC  = 4'b1001,   // ~F
        CC_GT  = 4'b1010,   // ~Z & ~L
        CC_LE  = 4'b1011,   // Z | L
        CC_HI  = 4'b1100,   // ~Z & ~N
        CC_LS  = 4'b1101,   // Z | N
        CC_AL  = 4'b1110,   // always
        CC_NV  = 4'b1111    // never
    } cond_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    wb_entry_t  buf_q [0:1];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q,  count_d;
    logic [4:0] psr_q,    psr_d;

    // Handshake decode
    logic       xfer;
    logic       push;
    logic       pop;
    wb_entry_t  new_entry;
    cond_e      cond_code;

    assign in_ready  = (count_q != 2'd2);
    assign wb_valid  = (count_q != 2'd0);
    assign xfer      = in_valid & in_ready;
    assign push      = xfer & in_wr_reg;
    assign pop       = wb_valid & wb_ready;
    assign new_entry = '{data: in_result, dest: in_dest};

    // Head entry always drives the writeback port
    assign wb_data = buf_q[rd_ptr_q].data;
    assign wb_dest = buf_q[rd_ptr_q].dest;

    assign psr   = psr_q;
    assign carry = psr_q[PSR_C];

    // -------------------------------------------------------------------------
    // FIFO pointer and occupancy next-state
    // -------------------------------------------------------------------------
    // Pointers wrap naturally as 1-bit values; count tracks push/pop balance
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // PSR next-state: masked flag merge, direct load has priority
    // -------------------------------------------------------------------------
    always_comb begin
        psr_d = psr_q;
        if (psr_load) begin
            psr_d = psr_data;
        end else if (xfer) begin
            psr_d = (psr_q & ~in_flag_mask) | (in_flags & in_flag_mask);
        end
    end

    // -------------------------------------------------------------------------
    // Control registers: pointers, occupancy and PSR
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            psr_q    <= 5'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            psr_q    <= psr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage: written at the tail on push
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset on purpose here: the head entry drives
            // wb_data/wb_dest directly, and those must read zero in reset.
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else if (push) begin
            buf_q[wr_ptr_q] <= new_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Branch condition evaluation against the current PSR
    // -------------------------------------------------------------------------
    assign cond_code = cond_e'(cond);

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_code)
            CC_EQ:   cond_true =  psr_q[PSR_Z];
            CC_NE:   cond_true = ~psr_q[PSR_Z];
            CC_CS:   cond_true =  psr_q[PSR_C];
            CC_CC:   cond_true = ~psr_q[PSR_C];
            CC_LT:   cond_true =  psr_q[PSR_L];
            CC_GE:   cond_true = ~psr_q[PSR_L];
            CC_MI:   cond_true =  psr_q[PSR_N];
            CC_PL:   cond_true = ~psr_q[PSR_N];
            CC_FS:   cond_true =  psr_q[PSR_F];
            CC_FC:   cond_true = ~psr_q[PSR_F];
            CC_GT:   cond_true = ~psr_q[PSR_Z] & ~psr_q[PSR_L];
            CC_LE:   cond_true =  psr_q[PSR_Z] |  psr_q[PSR_L];
            CC_HI:   cond_true = ~psr_q[PSR_Z] & ~psr_q[PSR_N];
            CC_LS:   cond_true =  psr_q[PSR_Z] |  psr_q[PSR_N];
            CC_AL:   cond_true = 1'b1;
            CC_NV:   cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exec_writeback.sv
// -----------------------------------------------------------------------------
// tb_exec_writeback
//   Directed scenarios for the writeback buffer, PSR update and condition
//   codes, followed by a randomized run compared against a queue-based
//   reference model of the stage.
// -----------------------------------------------------------------------------
module tb_exec_writeback;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready;
    logic [W-1:0] in_result;
    logic [4:0]   in_flags, in_flag_mask;
    logic         in_wr_reg;
    logic [3:0]   in_dest;
    logic         psr_load;
    logic [4:0]   psr_data, psr;
    logic         carry;
    logic [3:0]   cond;
    logic         cond_true;
    logic         wb_valid, wb_ready;
    logic [W-1:0] wb_data;
    logic [3:0]   wb_dest;

    int total = 0;
    int bad   = 0;

    // Reference model state
    typedef struct {
        logic [W-1:0] d;
        logic [3:0]   r;
    } ent_t;
    ent_t       m_q[$];
    logic [4:0] m_psr;

    exec_writeback #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_flag_mask (in_flag_mask),
        .in_wr_reg    (in_wr_reg),
        .in_dest      (in_dest),
        .psr_load     (psr_load),
        .psr_data     (psr_data),
        .psr          (psr),
        .carry        (carry),
        .cond         (cond),
        .cond_true    (cond_true),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_dest      (wb_dest)
    );

    always #5 clk = ~clk;

    // Condition truth from flag meanings: pairs of (base, inverted base)
    function automatic bit ref_cond(input logic [4:0] p, input logic [3:0] c);
        bit cf, lf, ff, zf, nf, base;
        cf = p[4]; lf = p[3]; ff = p[2]; zf = p[1]; nf = p[0];
        case (c[3:1])
            3'd0: base = zf;
            3'd1: base = cf;
            3'd2: base = lf;
            3'd3: base = nf;
            3'd4: base = ff;
            3'd5: base = !zf && !lf;
            3'd6: base = !zf && !nf;
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_result = '0; in_flags = '0; in_flag_mask = '0;
        in_wr_reg = 0; in_dest = '0; psr_load = 0; psr_data = '0;
        cond = '0; wb_ready = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        m_q.delete();
        m_psr = '0;
    endtask

    task automatic push_in(input logic [W-1:0] d, input logic [3:0] r);
        in_valid = 1; in_wr_reg = 1; in_result = d; in_dest = r;
        in_flags = '0; in_flag_mask = '0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        total++; if (psr !== 5'b0)    begin bad++; $display("FAIL reset_psr: got %b want 00000", psr); end
        total++; if (carry !== 1'b0)  begin bad++; $display("FAIL reset_carry: got %b want 0", carry); end
        total++; if (wb_valid !== 0)  begin bad++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        total++; if (in_ready !== 1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (wb_data !== '0)  begin bad++; $display("FAIL reset_wb_data: got %h want 0000", wb_data); end
        total++; if (wb_dest !== '0)  begin bad++; $display("FAIL reset_wb_dest: got %h want 0", wb_dest); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Single push, popped in the cycle it becomes visible
    task automatic test_single();
        @(negedge clk);
        in_valid = 1; in_result = 16'h1234; in_dest = 4'd3; in_wr_reg = 1;
        in_flags = 5'b10010; in_flag_mask = 5'b11111; wb_ready = 1;
        @(negedge clk);
        in_valid = 0;
        total++; if (wb_valid !== 1)         begin bad++; $display("FAIL single_valid: got %b want 1", wb_valid); end
        total++; if (wb_data !== 16'h1234)   begin bad++; $display("FAIL single_data: got %h want 1234", wb_data); end
        total++; if (wb_dest !== 4'd3)       begin bad++; $display("FAIL single_dest: got %h want 3", wb_dest); end
        total++; if (psr !== 5'b10010)       begin bad++; $display("FAIL single_psr: got %b want 10010", psr); end
        total++; if (carry !== 1'b1)         begin bad++; $display("FAIL single_carry: got %b want 1", carry); end
        @(negedge clk);
        total++; if (wb_valid !== 0)         begin bad++; $display("FAIL single_popped: got %b want 0", wb_valid); end
        idle_inputs();
    endtask

    // Fill the buffer with the port stalled, then drain in order
    task automatic test_back_to_back();
        @(negedge clk);
        idle_inputs();
        push_in(16'h0001, 4'd1);
        @(negedge clk);
        total++; if (in_ready !== 1) begin bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
        push_in(16'h0002, 4'd2);
        @(negedge clk);
        total++; if (in_ready !== 0) begin bad++; $display("FAIL b2b_ready2: got %b want 0", in_ready); end
        push_in(16'h0003, 4'd3);
        @(negedge clk);
        total++; if (in_ready !== 0)       begin bad++; $display("FAIL b2b_held: got %b want 0", in_ready); end
        total++; if (wb_data !== 16'h0001) begin bad++; $display("FAIL b2b_head1: got %h want 0001", wb_data); end
        wb_ready = 1;
        @(negedge clk);
        total++; if (wb_data !== 16'h0002) begin bad++; $display("FAIL b2b_head2: got %h want 0002", wb_data); end
        total++; if (in_ready !== 1)       begin bad++; $display("FAIL b2b_ready3: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        total++; if (wb_data !== 16'h0003) begin bad++; $display("FAIL b2b_head3: got %h want 0003", wb_data); end
        total++; if (wb_valid !== 1)       begin bad++; $display("FAIL b2b_valid3: got %b want 1", wb_valid); end
        @(negedge clk);
        total++; if (wb_valid !== 0)       begin bad++; $display("FAIL b2b_empty: got %b want 0", wb_valid); end
        idle_inputs();
    endtask

    // Direct PSR load wins over a same-cycle masked flag update
    task automatic test_psr_override();
        @(negedge clk);
        idle_inputs();
        psr_load = 1; psr_data = 5'b00000;
        @(negedge clk);
        total++; if (psr !== 5'b00000) begin bad++; $display("FAIL psr_clear: got %b want 00000", psr); end
        in_valid = 1; in_wr_reg = 0; in_flags = 5'b11111; in_flag_mask = 5'b00010;
        psr_load = 1; psr_data = 5'b10000;
        @(negedge clk);
        idle_inputs();
        total++; if (psr !== 5'b10000) begin bad++; $display("FAIL psr_override: got %b want 10000", psr); end
        total++; if (wb_valid !== 0)   begin bad++; $display("FAIL psr_nopush: got %b want 0", wb_valid); end
        // Masked update alone touches only the enabled bit
        in_valid = 1; in_flags = 5'b01011; in_flag_mask = 5'b00010;
        @(negedge clk);
        idle_inputs();
        total++; if (psr !== 5'b10010) begin bad++; $display("FAIL psr_masked: got %b want 10010", psr); end
    endtask

    // All sixteen codes with only Z set
    task automatic test_cond();
        logic [15:0] exp_z;
        exp_z = 16'h6AA9;   // bit i = expected cond_true for cond i with psr=00010
        @(negedge clk);
        idle_inputs();
        psr_load = 1; psr_data = 5'b00010;
        @(negedge clk);
        psr_load = 0;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            total++;
            if (cond_true !== exp_z[i]) begin
                bad++;
                $display("FAIL cond_z code=%b: got %b want %b", cond, cond_true, exp_z[i]);
            end
        end
        idle_inputs();
    endtask

    // Randomized traffic against the reference model
    task automatic test_random();
        bit xfer, pop;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            // Registered outputs at mid-cycle
            total++;
            if (in_ready !== (m_q.size() != 2)) begin
                bad++; $display("FAIL rnd_in_ready cyc=%0d: got %b want %b", n, in_ready, m_q.size() != 2);
            end
            total++;
            if (wb_valid !== (m_q.size() != 0)) begin
                bad++; $display("FAIL rnd_wb_valid cyc=%0d: got %b want %b", n, wb_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                total++;
                if (wb_data !== m_q[0].d || wb_dest !== m_q[0].r) begin
                    bad++; $display("FAIL rnd_head cyc=%0d: got %h/%h want %h/%h", n, wb_data, wb_dest, m_q[0].d, m_q[0].r);
                end
            end
            total++;
            if (psr !== m_psr || carry !== m_psr[4]) begin
                bad++; $display("FAIL rnd_psr cyc=%0d: got %b/%b want %b/%b", n, psr, carry, m_psr, m_psr[4]);
            end

            // New stimulus
            in_valid     = ($urandom_range(0, 3) != 0);
            in_result    = 16'($urandom);
            in_flags     = 5'($urandom);
            in_flag_mask = 5'($urandom);
            in_wr_reg    = ($urandom_range(0, 3) != 0);
            in_dest      = 4'($urandom);
            psr_load     = ($urandom_range(0, 7) == 0);
            psr_data     = 5'($urandom);
            cond         = 4'($urandom);
            wb_ready     = ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (cond_true !== ref_cond(m_psr, cond)) begin
                bad++; $display("FAIL rnd_cond cyc=%0d psr=%b code=%b: got %b want %b", n, m_psr, cond, cond_true, ref_cond(m_psr, cond));
            end

            // Advance the model across the edge
            @(posedge clk);
            xfer = in_valid && (m_q.size() != 2);
            pop  = (m_q.size() != 0) && wb_ready;
            if (pop) void'(m_q.pop_front());
            if (xfer && in_wr_reg) m_q.push_back('{d: in_result, r: in_dest});
            if (psr_load) begin
                m_psr = psr_data;
            end else if (xfer) begin
                for (int b = 0; b < 5; b++) if (in_flag_mask[b]) m_psr[b] = in_flags[b];
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // Reset in the middle of a cycle with two entries held
    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        psr_load = 1; psr_data = 5'b11011;
        push_in(16'hAAAA, 4'd5);
        @(negedge clk);
        psr_load = 0;
        push_in(16'hBBBB, 4'd6);
        @(negedge clk);
        in_valid = 0;
        total++; if (in_ready !== 0) begin bad++; $display("FAIL mid_full: got %b want 0", in_ready); end
        #2;
        rst_n = 0;
        #1;
        total++; if (wb_valid !== 0)    begin bad++; $display("FAIL mid_wb_valid: got %b want 0", wb_valid); end
        total++; if (psr !== 5'b0)      begin bad++; $display("FAIL mid_psr: got %b want 00000", psr); end
        total++; if (in_ready !== 1)    begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        total++; if (carry !== 0)       begin bad++; $display("FAIL mid_carry: got %b want 0", carry); end
        total++; if (wb_data !== '0)    begin bad++; $display("FAIL mid_wb_data: got %h want 0000", wb_data); end
        @(negedge clk);
        rst_n = 1;
        wb_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (wb_valid !== 0) begin bad++; $display("FAIL mid_after cyc=%0d: got %b want 0", i, wb_valid); end
        end
        idle_inputs();
    endtask

    initial begin
        m_psr = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_psr_override();
        test_cond();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
